mbl_pkt_rx: RTL

MBL_PKT_RX -- requirements
Module: mbl_pkt_rx

---
 rtl/mbl_pkg.sv | 24 ++
 rtl/autoinst_mplist_mbl_if.sv | 21 ++
 rtl/mbl_sync_fifo.sv | 72 +++++++
 rtl/mbl_pkt_rx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mbl_pkg.sv
// -----------------------------------------------------------------------------
// mbl_pkg
// Shared types for the packet receiver:
//   state_e - receive FSM states (IDLE, IN_PKT, DROP)
//   beat_t  - one buffered stream beat {sof, eof, data[31:0]}
//   BEAT_W  - width of beat_t in bits (buffer entry width)
// -----------------------------------------------------------------------------
package mbl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [31:0] data;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/autoinst_mplist_mbl_if.sv
// -----------------------------------------------------------------------------
// autoinst_mplist_mbl_if
// Valid/ready beat stream.
//   data[31:0], sof, eof, valid : driven by the master
//   ready                       : driven by the slave
// Modports:
//   master - produces beats (data/sof/eof/valid out, ready in)
//   slave  - consumes beats (data/sof/eof/valid in, ready out)
// -----------------------------------------------------------------------------
interface autoinst_mplist_mbl_if;

    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic        valid;
    logic        ready;

    modport master (output data, output sof, output eof, output valid, input ready);
    modport slave  (input data, input sof, input eof, input valid, output ready);

endinterface

// File: rtl/mbl_sync_fifo.sv
// -----------------------------------------------------------------------------
// mbl_sync_fifo
// Single-clock FIFO, DEPTH entries (power of 2, >= 2) of WIDTH bits.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata - write request / data (ignored when full)
//   pop         - read request (ignored when empty)
//   rdata       - head entry; forced to zero while empty
//   full, empty - status from registered occupancy
// -----------------------------------------------------------------------------
module mbl_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Zero the head while empty so stale storage never reaches the outputs.
    assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/mbl_pkt_rx.sv
// -----------------------------------------------------------------------------
// mbl_pkt_rx
// Packet receiver: checks sof/eof framing of the upstream stream, repairs or
// drops malformed traffic, and buffers well-formed packets for downstream.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_if       - upstream stream (slave): ready = buffer not full
//   out_if      - downstream stream (master): head of the buffer
//   pkt_cnt     - packets written to the buffer (wraps at 16 bits)
//   err_orphan  - pulse: beat without sof accepted outside a packet
//   err_sof     - pulse: sof seen inside a packet (sof stripped)
//   err_len     - pulse: packet truncated at MAX_LEN beats
// Pulses and pkt_cnt are registered: they appear the cycle after the beat
// that caused them is accepted.
// -----------------------------------------------------------------------------
module mbl_pkt_rx
    import mbl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    autoinst_mplist_mbl_if.slave  in_if,
    autoinst_mplist_mbl_if.master out_if,
    output logic [15:0]           pkt_cnt,
    output logic                  err_orphan,
    output logic                  err_sof,
    output logic                  err_len
);

    // Wide enough to hold MAX_LEN itself, so the count never wraps in a packet.
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_inc;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic             err_orphan_q, err_orphan_d;
    logic             err_sof_q, err_sof_d;
    logic             err_len_q, err_len_d;
    logic             pkt_done;
    logic             accept;
    logic             wr_en;
    beat_t            wr_beat;
    beat_t            rd_beat;
    logic             fifo_full;
    logic             fifo_empty;

    // ready depends only on registered occupancy, never on valid.
    assign in_if.ready = !fifo_full;
    assign accept      = in_if.valid && !fifo_full;
    assign len_inc     = len_q + LEN_ONE;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pkt_done     = 1'b0;
        wr_en        = 1'b0;
        err_orphan_d = 1'b0;
        err_sof_d    = 1'b0;
        err_len_d    = 1'b0;
        wr_beat.sof  = in_if.sof;
        wr_beat.eof  = in_if.eof;
        wr_beat.data = in_if.data;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_if.sof) begin
                        err_orphan_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (in_if.eof) begin
                            pkt_done = 1'b1;
                        end else begin
                            len_d   = LEN_ONE;
                            state_d = IN_PKT;
                        end
                    end
                end
                IN_PKT: begin
                    // A stray sof is reported and stripped; the beat then
                    // continues the current packet.
                    wr_en       = 1'b1;
                    wr_beat.sof = 1'b0;
                    err_sof_d   = in_if.sof;
                    if (in_if.eof) begin
                        pkt_done = 1'b1;
                        len_d    = '0;
                        state_d  = IDLE;
                    end else if (len_inc == MAX_LEN_C) begin
                        // Close the packet here and swallow the rest of it.
                        wr_beat.eof = 1'b1;
                        pkt_done    = 1'b1;
                        err_len_d   = 1'b1;
                        len_d       = '0;
                        state_d     = DROP;
                    end else begin
                        len_d = len_inc;
                    end
                end
                DROP: begin
                    if (in_if.eof) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            endcase
        end

        pkt_cnt_d = pkt_cnt_q + 16'(pkt_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            pkt_cnt_q    <= '0;
            err_orphan_q <= 1'b0;
            err_sof_q    <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_orphan_q <= err_orphan_d;
            err_sof_q    <= err_sof_d;
            err_len_q    <= err_len_d;
        end
    end

    mbl_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .wdata (wr_beat),
        .pop   (out_if.ready),
        .rdata (rd_beat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_if.valid = !fifo_empty;
    assign out_if.sof   = rd_beat.sof;
    assign out_if.eof   = rd_beat.eof;
    assign out_if.data  = rd_beat.data;

    assign pkt_cnt    = pkt_cnt_q;
    assign err_orphan = err_orphan_q;
    assign err_sof    = err_sof_q;
    assign err_len    = err_len_q;

endmodule
